// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: valid/ready pipeline stage register with optional skid entry, flush and stall counter
module pipe_stage_hs #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 16,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);
  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic              in_xfer;
  logic              out_xfer;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = main_valid && out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  if (SKID != 0) begin : g_skid
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
    state_t            state;
    state_t            state_nx;
    logic              rdy_q;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              load_in;
    logic              to_skid;
    logic              from_skid;
    assign in_ready   = rdy_q;
    assign main_valid = state != EMPTY;
    assign occupancy  = state;
    assign load_in    = in_xfer && (!main_valid || out_xfer);
    assign to_skid    = in_xfer && main_valid && !out_xfer;
    assign from_skid  = state == TWO && out_xfer;
    // next state: flush empties the stage, otherwise count entries in minus out
    always_comb begin
      state_nx = flush ? EMPTY :
                 state == EMPTY ? (in_xfer ? ONE : EMPTY) :
                 state == ONE   ? (to_skid ? TWO : (out_xfer && !in_xfer) ? EMPTY : ONE) :
                 (out_xfer ? ONE : TWO);
    end
    // state register; in_ready is precomputed from the next state so it leaves a flop
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= EMPTY;
        rdy_q <= 1'b1;
      end else begin
        state <= state_nx;
        rdy_q <= state_nx != TWO;
      end
    end
    // payload: control is killed by flush, data is left stale
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        main_data <= '0;
        main_ctrl <= '0;
        skid_data <= '0;
        skid_ctrl <= '0;
      end else if (flush) begin
        main_ctrl <= '0;
        skid_ctrl <= '0;
      end else begin
        if (load_in) begin
          main_data <= in_data;
          main_ctrl <= in_ctrl;
        end else if (from_skid) begin
          main_data <= skid_data;
          main_ctrl <= skid_ctrl;
          skid_ctrl <= '0;
        end
        if (to_skid) begin
          skid_data <= in_data;
          skid_ctrl <= in_ctrl;
        end
      end
    end
  end else begin : g_reg
    assign in_ready  = !main_valid || out_ready;
    assign occupancy = {1'b0, main_valid};
    // single register: load on accept, drain on delivery, flush kills control
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        main_valid <= 1'b0;
        main_data  <= '0;
        main_ctrl  <= '0;
      end else if (flush) begin
        main_valid <= 1'b0;
        main_ctrl  <= '0;
      end else if (in_xfer) begin
        main_valid <= 1'b1;
        main_data  <= in_data;
        main_ctrl  <= in_ctrl;
      end else if (out_xfer) begin
        main_valid <= 1'b0;
      end
    end
  end
  // saturating count of back-pressured cycles, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
  end
endmodule
